mem_arb_nch: RTL and testbench

- Parametrised N-channel arbiter between cache-side DRAM clients (icache, dcache, future prefetcher) and the single burst memory port (bmem).
- Supports fixed-priority or round-robin arbitration.
- Keeps a write grant locked for the whole burst.
- Routes in-order read bursts to the issuing channel through a tag FIFO, so several reads can be outstanding.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_nch_fifo.sv | 33 +++
 rtl/mem_arb_nch.sv | 109 ++++++++++
 tb/tb_mem_arb_nch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and width helpers for the N-channel memory arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, WBURST} arb_state_t;
  function automatic int ch_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int burst_cnt_w(input int bl);
    return bl > 1 ? $clog2(bl) : 1;
  endfunction
endpackage

// File: rtl/mem_arb_nch_fifo.sv
// arb_tag_fifo: sync FIFO of channel indices for in-order read response routing
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arb_nch.sv
// mem_arb_nch: N-channel burst memory arbiter with write-burst lock and tagged read routing
module mem_arb_nch
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BURST_LEN = 4,
  parameter bit RR_MODE = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [ADDR_W-1:0]        ch_raddr,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [ADDR_W-1:0]        bmem_addr,
  output logic                     bmem_read,
  output logic                     bmem_write,
  output logic [DATA_W-1:0]        bmem_wdata,
  input  logic                     bmem_ready,
  input  logic [ADDR_W-1:0]        bmem_raddr,
  input  logic [DATA_W-1:0]        bmem_rdata,
  input  logic                     bmem_rvalid,
  output logic                     err_spurious
);
  localparam int CW = ch_idx_w(NUM_CH);
  localparam int BW = burst_cnt_w(BURST_LEN);
  arb_state_t state, state_d;
  logic [CW-1:0] rr_ptr, wch, g, head;
  logic [BW-1:0] wbeat, rbeat;
  logic [NUM_CH-1:0] elig;
  logic full, empty, gnt, rd, wr, push, pop, rv, err, wlast;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
    return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    int c;
    c = 0;
    g = '0;
    gnt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) elig[i] = ch_read[i] ? ~full : ch_write[i];
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = RR_MODE ? (int'(rr_ptr) + k) % NUM_CH : k;
      if (elig[c]) begin
        g = CW'(c);
        gnt = 1'b1;
      end
    end
    if (state == WBURST) begin
      g = wch;
      gnt = 1'b1;
    end
    rd = ~rst & gnt & (state == IDLE) & ch_read[g];
    wr = ~rst & gnt & ~rd & ch_write[g];
    wlast = wbeat == BW'(BURST_LEN - 1);
    state_d = state;
    if (state == IDLE && wr && bmem_ready) state_d = WBURST;
    if (state == WBURST && wr && bmem_ready && wlast) state_d = IDLE;
  end

  assign push = rd & bmem_ready;
  assign rv = ~rst & bmem_rvalid & ~empty;
  assign pop = rv & (rbeat == BW'(BURST_LEN - 1));
  assign bmem_read = rd;
  assign bmem_write = wr;
  assign bmem_addr = (rd | wr) ? ch_addr[g*ADDR_W +: ADDR_W] : '0;
  assign bmem_wdata = wr ? ch_wdata[g*DATA_W +: DATA_W] : '0;
  assign ch_ready = ((rd | wr) & bmem_ready) ? NUM_CH'(1) << g : '0;
  assign ch_rvalid = rv ? NUM_CH'(1) << head : '0;
  assign ch_raddr = rst ? '0 : bmem_raddr;
  assign ch_rdata = rst ? '0 : bmem_rdata;
  assign err_spurious = err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      wch <= '0;
      wbeat <= '0;
      rbeat <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      if (push) rr_ptr <= inc(g);
      if (state == IDLE && wr && bmem_ready) begin
        wch <= g;
        wbeat <= BW'(1);
      end else if (state == WBURST && wr && bmem_ready) begin
        wbeat <= wlast ? '0 : wbeat + 1'b1;
        if (wlast) rr_ptr <= inc(wch);
      end
      if (rv) rbeat <= pop ? '0 : rbeat + 1'b1;
      if (bmem_rvalid && empty) err <= 1'b1;
    end
  end

  arb_tag_fifo #(.DEPTH(MAX_OUTST), .W(CW)) u_tags (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(g), .dout(head), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_mem_arb_nch.sv
// tb_mem_arb_nch: table vectors, directed corner sequences and random traffic against a queue model
module tb_mem_arb_nch;
  localparam int N = 2, AW = 32, DW = 64, BL = 4, MO = 4;
  logic clk = 0, rst;
  logic [N*AW-1:0] ch_addr;
  logic [N-1:0] ch_read, ch_write, ch_ready, ch_rvalid;
  logic [N*DW-1:0] ch_wdata;
  logic [AW-1:0] ch_raddr, bmem_addr, bmem_raddr;
  logic [DW-1:0] ch_rdata, bmem_wdata, bmem_rdata;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid, err_spurious;

  mem_arb_nch #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RR_MODE(1), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst), .ch_addr(ch_addr), .ch_read(ch_read), .ch_write(ch_write),
    .ch_wdata(ch_wdata), .ch_ready(ch_ready), .ch_raddr(ch_raddr), .ch_rdata(ch_rdata),
    .ch_rvalid(ch_rvalid), .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int q[$];
  int m_rr, m_wch, m_wb, m_rb, m_g;
  bit m_lock, m_err, m_push, m_wacc, m_rv, m_spur;
  logic [N-1:0] rdy_s;

  typedef struct {
    logic [1:0] rd, wr;
    logic exp_rd, exp_wr;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic set_addr(input int c, input logic [31:0] a);
    ch_addr[c*AW +: AW] = a;
  endtask

  task automatic clr();
    ch_read = '0; ch_write = '0; bmem_ready = 0; bmem_rvalid = 0;
  endtask

  task automatic settle();
    bit gnt, rd, wr;
    logic [N-1:0] e_rdy, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #1;
    gnt = 0; m_g = 0; rd = 0; wr = 0;
    if (!rst) begin
      if (m_lock) begin m_g = m_wch; gnt = 1; end
      else for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!gnt && (ch_read[c] ? q.size() < MO : ch_write[c])) begin m_g = c; gnt = 1; end
      end
      rd = gnt && !m_lock && ch_read[m_g];
      wr = gnt && !rd && ch_write[m_g];
    end
    m_push = rd && bmem_ready;
    m_wacc = wr && bmem_ready;
    m_rv = !rst && bmem_rvalid && q.size() > 0;
    m_spur = !rst && bmem_rvalid && q.size() == 0;
    e_rdy = (rd || wr) && bmem_ready ? N'(1) << m_g : '0;
    e_rv = m_rv ? N'(1) << q[0] : '0;
    e_addr = (rd || wr) ? ch_addr[m_g*AW +: AW] : '0;
    e_wd = wr ? ch_wdata[m_g*DW +: DW] : '0;
    chk("m_ch_ready", ch_ready, e_rdy);
    chk("m_bmem_read", bmem_read, rd);
    chk("m_bmem_write", bmem_write, wr);
    chk("m_bmem_addr", bmem_addr, e_addr);
    chk("m_bmem_wdata", bmem_wdata, e_wd);
    chk("m_ch_rvalid", ch_rvalid, e_rv);
    chk("m_ch_rdata", ch_rdata, rst ? '0 : bmem_rdata);
    chk("m_err", err_spurious, !rst && m_err);
    rdy_s = ch_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete(); m_rr = 0; m_lock = 0; m_wch = 0; m_wb = 0; m_rb = 0; m_err = 0;
    end else begin
      if (m_push) begin q.push_back(m_g); m_rr = (m_g + 1) % N; end
      if (m_wacc) begin
        if (!m_lock) begin m_lock = 1; m_wch = m_g; m_wb = 1; end
        else if (++m_wb == BL) begin m_lock = 0; m_wb = 0; m_rr = (m_wch + 1) % N; end
      end
      if (m_rv && ++m_rb == BL) begin void'(q.pop_front()); m_rb = 0; end
      if (m_spur) m_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic drain(input int beats, input logic [N-1:0] exp_rv);
    bmem_rvalid = 1;
    for (int i = 0; i < beats; i++) begin
      settle();
      chk("drain_rvalid", ch_rvalid, exp_rv);
      tick();
    end
    bmem_rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int wleft[N];
    logic [N-1:0] ew[5];
    logic [N-1:0] exp_rdy;
    tbl[0] = '{2'b01, 2'b00, 1, 0, 32'h1000};
    tbl[1] = '{2'b10, 2'b00, 1, 0, 32'h2000};
    tbl[2] = '{2'b11, 2'b00, 1, 0, 32'h1000};
    tbl[3] = '{2'b00, 2'b10, 0, 1, 32'h2000};
    tbl[4] = '{2'b10, 2'b01, 0, 1, 32'h1000};
    tbl[5] = '{2'b00, 2'b00, 0, 0, 32'h0};
    tbl[6] = '{2'b01, 2'b01, 1, 0, 32'h1000};
    tbl[7] = '{2'b00, 2'b11, 0, 1, 32'h1000};
    ch_addr = '0; ch_wdata = '0; bmem_raddr = '0; bmem_rdata = '0;
    clr();
    rst = 1;
    @(negedge clk);
    // outputs must read zero while reset is held, even with live inputs
    ch_read = 2'b11; bmem_ready = 1; bmem_rvalid = 1; bmem_rdata = 64'hdead_beef; bmem_raddr = 32'h44;
    settle();
    chk("rst_read", bmem_read, 0);
    chk("rst_ready", ch_ready, 0);
    chk("rst_rvalid", ch_rvalid, 0);
    chk("rst_rdata", ch_rdata, 0);
    chk("rst_raddr", ch_raddr, 0);
    tick();
    clr();
    cyc();
    rst = 0;
    set_addr(0, 32'h1000); set_addr(1, 32'h2000);
    foreach (tbl[i]) begin
      ch_read = tbl[i].rd; ch_write = tbl[i].wr;
      settle();
      chk("tbl_read", bmem_read, tbl[i].exp_rd);
      chk("tbl_write", bmem_write, tbl[i].exp_wr);
      chk("tbl_addr", bmem_addr, tbl[i].exp_addr);
      tick();
    end
    clr();
    // single read on ch1
    ch_read = 2'b10; set_addr(1, 32'h100); bmem_ready = 1;
    settle();
    chk("sr_read", bmem_read, 1);
    chk("sr_addr", bmem_addr, 32'h100);
    chk("sr_ready", ch_ready, 2'b10);
    tick();
    ch_read = 0;
    settle();
    chk("sr_read_done", bmem_read, 0);
    tick();
    drain(4, 2'b10);
    // round-robin alternation, fills the tag FIFO
    ch_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_grant", ch_ready, i % 2 ? 2'b10 : 2'b01);
      tick();
    end
    ch_read = 0;
    drain(4, 2'b01); drain(4, 2'b10); drain(4, 2'b01); drain(4, 2'b10);
    // locked write burst with ch1 read pending and stalling memory
    ch_write = 2'b01; set_addr(0, 32'h200); ch_read = 2'b10;
    ew = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 5; i++) begin
      bmem_ready = (i != 1);
      ch_wdata[DW-1:0] = 64'ha0 + 64'(i);
      settle();
      chk("wb_write", bmem_write, 1);
      chk("wb_ready", ch_ready, ew[i]);
      chk("wb_addr", bmem_addr, 32'h200);
      tick();
    end
    ch_write = 0;
    settle();
    chk("wb_after", ch_ready, 2'b10);
    tick();
    ch_read = 0;
    drain(4, 2'b10);
    // outstanding limit
    ch_read = 2'b01; bmem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ost_accept", ch_ready, 2'b01);
      tick();
    end
    settle();
    chk("ost_full", ch_ready, 2'b00);
    tick();
    bmem_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ost_block", ch_ready, 2'b00);
      tick();
    end
    bmem_rvalid = 0;
    settle();
    chk("ost_fifth", ch_ready, 2'b01);
    tick();
    ch_read = 0;
    drain(16, 2'b01);
    // interleaved returns then a stray beat
    ch_read = 2'b01; cyc();
    ch_read = 2'b10; cyc();
    ch_read = 0;
    drain(4, 2'b01); drain(4, 2'b10);
    settle();
    chk("err_before", err_spurious, 0);
    tick();
    bmem_rvalid = 1;
    settle();
    chk("stray_rvalid", ch_rvalid, 0);
    tick();
    bmem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("err_sticky", err_spurious, 1);
      tick();
    end
    // reset in the middle of a write burst
    ch_write = 2'b01; set_addr(0, 32'h300);
    cyc(); cyc();
    rst = 1; ch_write = 0;
    settle();
    chk("rw_write", bmem_write, 0);
    tick();
    rst = 0; ch_read = 2'b10;
    settle();
    chk("rw_ready", ch_ready, 2'b10);
    chk("rw_nowrite", bmem_write, 0);
    chk("rw_err", err_spurious, 0);
    tick();
    ch_read = 0;
    // random traffic against the model
    foreach (wleft[c]) wleft[c] = 0;
    rdy_s = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (ch_read[c] && rdy_s[c]) ch_read[c] = 0;
        else if (ch_write[c] && rdy_s[c]) begin
          wleft[c]--;
          ch_wdata[c*DW +: DW] = {$urandom, $urandom};
          ch_write[c] = wleft[c] > 0 && ($urandom % 4 != 0);
        end else if (!ch_write[c] && wleft[c] > 0) ch_write[c] = $urandom % 2;
        else if (!ch_read[c] && !ch_write[c]) begin
          int r;
          r = $urandom % 8;
          if (r < 2) begin ch_read[c] = 1; set_addr(c, $urandom); end
          else if (r == 2) begin
            ch_write[c] = 1; wleft[c] = BL; set_addr(c, $urandom);
            ch_wdata[c*DW +: DW] = {$urandom, $urandom};
          end
        end
      end
      bmem_ready = $urandom % 4 != 0;
      bmem_rvalid = q.size() > 0 && ($urandom % 2 == 1);
      bmem_rdata = {$urandom, $urandom};
      bmem_raddr = $urandom;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
